// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  // Bit-counter width; clamped to 1 so a degenerate width still yields a legal vector.
  function automatic int unsigned cntWidth(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  localparam int unsigned DefaultCntWidth = cntWidth(DefaultWidth);

endpackage

// File: rtl/fullsubtractor.sv
// One-bit full-subtractor cell: d = a - b - bin, bo = borrow out.
module fullsubtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bin;
  assign bo = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: DIFF = A - B - bin, one bit per clock, LSB first,
// with a start/busy/done handshake and results held until the next run completes.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int unsigned CntW = cntWidth(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  stateT            state;
  stateT            stateNext;
  logic [CntW-1:0]  cnt;
  logic             br;
  logic [WIDTH-1:0] aSh;
  logic [WIDTH-1:0] bSh;
  logic [WIDTH-1:0] resSh;
  logic [WIDTH-1:0] resNext;
  logic             aMsb;
  logic             bMsb;
  logic             cellD;
  logic             cellBo;
  logic             accept;
  logic             lastBit;

  fullsubtractor uCell (
    .a   (aSh[0]),
    .b   (bSh[0]),
    .bin (br),
    .d   (cellD),
    .bo  (cellBo)
  );

  assign resNext = {cellD, resSh[WIDTH-1:1]};

  // Next-state logic; start is only honoured in IDLE and DONE.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    lastBit   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          stateNext = RUN;
        end
      end
      RUN: begin
        if (cnt == LastCnt) begin
          lastBit   = 1'b1;
          stateNext = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          stateNext = RUN;
        end else begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Operand shifters, borrow register and bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aSh   <= '0;
      bSh   <= '0;
      resSh <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      aMsb  <= 1'b0;
      bMsb  <= 1'b0;
    end else if (accept) begin
      aSh   <= a;
      bSh   <= b;
      resSh <= '0;
      br    <= bin;
      cnt   <= '0;
      aMsb  <= a[WIDTH-1];
      bMsb  <= b[WIDTH-1];
    end else if (state == RUN) begin
      aSh   <= aSh >> 1;
      bSh   <= bSh >> 1;
      resSh <= resNext;
      br    <= cellBo;
      cnt   <= cnt + CntW'(1);
    end
  end

  // Registered handshake and result outputs; results captured on the final bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
      zero <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      busy <= (stateNext == RUN);
      done <= (stateNext == DONE);
      if (lastBit) begin
        diff <= resNext;
        bout <= cellBo;
        zero <= (resNext == '0);
        ovf  <= (aMsb != bMsb) && (cellD != aMsb);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): directed vectors, back-to-back,
// ignored start while busy, and asynchronous reset mid-run.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         ovf;
    int           cyc;
  } expT;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         zero;
  logic         ovf;

  int  cyc = 0;
  int  nChecks = 0;
  int  nFail = 0;
  expT sb[$];

  // Hand-computed vectors: a, b, bin -> diff, bout, zero, ovf.
  logic [W-1:0] va   [6] = '{8'h50, 8'h20, 8'h80, 8'h33, 8'h00, 8'h7F};
  logic [W-1:0] vb   [6] = '{8'h20, 8'h50, 8'h01, 8'h33, 8'h00, 8'hFF};
  logic         vbin [6] = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b0};
  logic [W-1:0] ed   [6] = '{8'h30, 8'hD0, 8'h7F, 8'h00, 8'hFF, 8'h80};
  logic         eb   [6] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b1};
  logic         ez   [6] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
  logic         eo   [6] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1};

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .zero  (zero),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge: drive vector i and queue its expected response.
  task automatic issue(input int i);
    expT e;
    start = 1'b1;
    a     = va[i];
    b     = vb[i];
    bin   = vbin[i];
    e.diff = ed[i];
    e.bout = eb[i];
    e.zero = ez[i];
    e.ovf  = eo[i];
    e.cyc  = cyc + 1 + W;
    sb.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        nChecks++;
        nFail++;
        $display("FAIL unexpectedDone: done=1 with nothing pending (cycle %0d)", cyc);
      end else begin
        expT e;
        e = sb.pop_front();
        chk("diff", int'(diff), int'(e.diff));
        chk("bout", int'(bout), int'(e.bout));
        chk("zero", int'(zero), int'(e.zero));
        chk("ovf", int'(ovf), int'(e.ovf));
        chk("doneCycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    #1;
    chk("resetBusy", int'(busy), 0);
    chk("resetDone", int'(done), 0);
    chk("resetDiff", int'(diff), 0);
    chk("resetFlags", int'({bout, zero, ovf}), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Isolated operations; operands scrambled after acceptance.
    for (int i = 0; i < 6; i++) begin
      issue(i);
      @(negedge clk);
      start = 1'b0;
      a     = 8'($urandom);
      b     = 8'($urandom);
      bin   = 1'($urandom);
      repeat (12) @(negedge clk);
    end

    // Back-to-back: next start lands in the DONE cycle.
    for (int i = 0; i < 5; i++) begin
      issue(i);
      @(negedge clk);
      start = 1'b0;
      repeat (W) @(negedge clk);
    end
    repeat (4) @(negedge clk);

    // start re-pulsed during RUN is ignored.
    issue(0);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("busyInRun", int'(busy), 1);
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'h01;
    bin   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // Asynchronous reset between edges aborts the run.
    start = 1'b1;
    a     = 8'h50;
    b     = 8'h20;
    bin   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abortBusy", int'(busy), 0);
    chk("abortDone", int'(done), 0);
    chk("abortDiff", int'(diff), 0);
    chk("abortFlags", int'({bout, zero, ovf}), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    // Normal operation after abort.
    issue(2);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);

    chk("pendingResults", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
